// File: rtl/spinnaker_fpgas_reg_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: FSM encoding, default widths
// and the register address map common with the register bank.
package spinnaker_fpgas_reg_arbiter_pkg;

  localparam int unsigned DEF_REGA_BITS = 14;
  localparam int unsigned DEF_REGD_BITS = 32;

  localparam logic [DEF_REGA_BITS-1:0] VERS_REG = 14'd0;
  localparam logic [DEF_REGA_BITS-1:0] FLAG_REG = 14'd1;
  localparam logic [DEF_REGA_BITS-1:0] PKEY_REG = 14'd2;
  localparam logic [DEF_REGA_BITS-1:0] PMSK_REG = 14'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/spinnaker_fpgas_reg_arbiter_if.sv
// Requester and register-bank signals of the arbiter; slave is the arbiter side,
// master is the side made of the requesters plus the register bank.
interface spinnaker_fpgas_reg_arbiter_if
  import spinnaker_fpgas_reg_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned REGA_BITS = DEF_REGA_BITS,
  parameter int unsigned REGD_BITS = DEF_REGD_BITS
);

  logic [NUM_REQ-1:0]           REQ_IN;
  logic [NUM_REQ-1:0]           WR_IN;
  logic [NUM_REQ*REGA_BITS-1:0] ADDR_IN;
  logic [NUM_REQ*REGD_BITS-1:0] WDATA_IN;
  logic [NUM_REQ-1:0]           ACK_OUT;
  logic [REGD_BITS-1:0]         RDATA_OUT;
  logic                         BANK_WRITE;
  logic [REGA_BITS-1:0]         BANK_ADDR;
  logic [REGD_BITS-1:0]         BANK_WDATA;
  logic [REGD_BITS-1:0]         BANK_RDATA;

  modport slave (
    input  REQ_IN, WR_IN, ADDR_IN, WDATA_IN, BANK_RDATA,
    output ACK_OUT, RDATA_OUT, BANK_WRITE, BANK_ADDR, BANK_WDATA
  );

  modport master (
    output REQ_IN, WR_IN, ADDR_IN, WDATA_IN, BANK_RDATA,
    input  ACK_OUT, RDATA_OUT, BANK_WRITE, BANK_ADDR, BANK_WDATA
  );

endinterface

// File: rtl/spinnaker_fpgas_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module spinnaker_fpgas_rr_pick #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned PTR_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic                valid,
  output logic [PTR_BITS-1:0] winner
);

  int unsigned idx;
  logic        found;

  always_comb begin
    valid  = |req;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[idx[PTR_BITS-1:0]]) begin
        found  = 1'b1;
        winner = idx[PTR_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/spinnaker_fpgas_reg_arbiter.sv
// Shares the control/diagnostic register bank port between NUM_REQ requesters,
// one access at a time, granted round-robin, completed by a one-cycle ACK.
module spinnaker_fpgas_reg_arbiter
  import spinnaker_fpgas_reg_arbiter_pkg::*;
#(
  parameter int unsigned REGA_BITS = DEF_REGA_BITS,
  parameter int unsigned REGD_BITS = DEF_REGD_BITS,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic                         CLK_IN,
  input  logic                         RESET_IN,
  spinnaker_fpgas_reg_arbiter_if.slave bus
);

  localparam int unsigned PTR_BITS = $clog2(NUM_REQ);

  arb_state_t          state;
  logic [PTR_BITS-1:0] ptr;
  logic [PTR_BITS-1:0] win_idx;
  logic [PTR_BITS-1:0] pick_idx;
  logic                pick_valid;

  spinnaker_fpgas_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .PTR_BITS (PTR_BITS)
  ) u_pick (
    .req    (bus.REQ_IN),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // BANK_ADDR/BANK_WDATA/BANK_WRITE double as the holding registers: they are
  // loaded from the winner in IDLE, so they are valid for the whole ACCESS cycle.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state          <= IDLE;
      ptr            <= '0;
      win_idx        <= '0;
      bus.ACK_OUT    <= '0;
      bus.RDATA_OUT  <= '0;
      bus.BANK_WRITE <= 1'b0;
      bus.BANK_ADDR  <= '0;
      bus.BANK_WDATA <= '0;
    end else begin
      bus.ACK_OUT    <= '0;
      bus.BANK_WRITE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            win_idx        <= pick_idx;
            bus.BANK_WRITE <= bus.WR_IN[pick_idx];
            bus.BANK_ADDR  <= bus.ADDR_IN[32'(pick_idx)*REGA_BITS +: REGA_BITS];
            bus.BANK_WDATA <= bus.WDATA_IN[32'(pick_idx)*REGD_BITS +: REGD_BITS];
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          bus.RDATA_OUT        <= bus.BANK_RDATA;
          bus.ACK_OUT[win_idx] <= 1'b1;
          state                <= DONE;
        end
        DONE: begin
          ptr   <= (win_idx == PTR_BITS'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
